// File: rtl/ibex_register_file_arbiter_pkg.sv
// Shared types and helpers for the register file arbiter: FSM state encoding and
// the effective register count for RV32E / RV32I configurations.
package ibex_register_file_arbiter_pkg;

    typedef enum logic [1:0] {
        RF_ARB_CLEAR,
        RF_ARB_IDLE,
        RF_ARB_DBG_RESP
    } rf_arb_state_e;

    function automatic int unsigned num_regs_eff(input bit rv32e, input int unsigned num_regs);
        return rv32e ? 32'd16 : num_regs;
    endfunction

endpackage

// File: rtl/ibex_register_file_arbiter.sv
// Arbitrates the single write port of a reset-less FPGA register file between a
// hardware clear sweep, core writeback and a debug access port.
module ibex_register_file_arbiter
    import ibex_register_file_arbiter_pkg::*;
#(
    parameter bit                    RV32E        = 1'b0,
    parameter int unsigned           DataWidth    = 32,
    parameter int unsigned           NumRegs      = 32,
    parameter logic [DataWidth-1:0]  WordZeroVal  = '0,
    parameter bit                    ClearOnReset = 1'b1,
    localparam int unsigned          ADDR_WIDTH   = $clog2(NumRegs)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  clear_req_i,
    output logic                  busy_o,
    output logic                  core_stall_o,

    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_i,
    input  logic [DataWidth-1:0]  core_wdata_i,
    input  logic [ADDR_WIDTH-1:0] core_raddr_b_i,

    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]  rf_wdata_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
    input  logic [DataWidth-1:0]  rf_rdata_b_i,

    input  logic                  dbg_req_i,
    output logic                  dbg_gnt_o,
    input  logic                  dbg_we_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DataWidth-1:0]  dbg_wdata_i,
    output logic                  dbg_rvalid_o,
    output logic [DataWidth-1:0]  dbg_rdata_o,
    output logic                  dbg_err_o
);

    localparam int unsigned           NumRegsEff   = num_regs_eff(RV32E, NumRegs);
    localparam logic [ADDR_WIDTH-1:0] ClrLast      = ADDR_WIDTH'(NumRegsEff - 1);
    localparam logic [ADDR_WIDTH:0]   NumRegsEffW  = (ADDR_WIDTH + 1)'(NumRegsEff);
    localparam rf_arb_state_e         ResetState   = ClearOnReset ? RF_ARB_CLEAR : RF_ARB_IDLE;

    rf_arb_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  dbg_addr_oor;
    logic                  dbg_addr_zero;

    assign dbg_addr_oor  = {1'b0, dbg_addr_i} >= NumRegsEffW;
    assign dbg_addr_zero = (dbg_addr_i == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ResetState;
            clr_cnt_q <= ADDR_WIDTH'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        rf_we_o      = core_we_i && (core_waddr_i != '0);
        rf_waddr_o   = core_waddr_i;
        rf_wdata_o   = core_wdata_i;
        rf_raddr_b_o = core_raddr_b_i;
        busy_o       = 1'b0;
        core_stall_o = 1'b0;
        dbg_gnt_o    = 1'b0;

        unique case (state_q)
            RF_ARB_CLEAR: begin
                // Address 0 is hardwired zero, so the sweep starts at 1.
                rf_we_o      = 1'b1;
                rf_waddr_o   = clr_cnt_q;
                rf_wdata_o   = WordZeroVal;
                busy_o       = 1'b1;
                core_stall_o = 1'b1;
                if (clr_cnt_q == ClrLast) begin
                    state_d   = RF_ARB_IDLE;
                    clr_cnt_d = ADDR_WIDTH'(1);
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            RF_ARB_IDLE: begin
                if (clear_req_i) begin
                    state_d = RF_ARB_CLEAR;
                end else if (dbg_req_i && !core_we_i) begin
                    // Debug owns both ports for this cycle; the core is held off.
                    dbg_gnt_o    = 1'b1;
                    core_stall_o = 1'b1;
                    rf_raddr_b_o = dbg_addr_i;
                    rf_we_o      = dbg_we_i && !dbg_addr_zero && !dbg_addr_oor;
                    rf_waddr_o   = dbg_addr_i;
                    rf_wdata_o   = dbg_wdata_i;
                    state_d      = RF_ARB_DBG_RESP;
                end
            end
            RF_ARB_DBG_RESP: begin
                state_d = RF_ARB_IDLE;
            end
            default: begin
                state_d = RF_ARB_IDLE;
            end
        endcase
    end

    // Response captures the pre-write read value at grant time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dbg_rvalid_o <= 1'b0;
            dbg_rdata_o  <= '0;
            dbg_err_o    <= 1'b0;
        end else begin
            dbg_rvalid_o <= dbg_gnt_o;
            if (dbg_gnt_o) begin
                dbg_rdata_o <= (dbg_addr_oor || dbg_addr_zero) ? '0 : rf_rdata_b_i;
                dbg_err_o   <= dbg_addr_oor;
            end
        end
    end

endmodule
